dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the pipeline memory stage (CPU port) and one external master (EXT port: loader/debug/DMA).
- One access per clock.
- CPU has priority. A saturating wait counter guarantees EXT service within MAX_WAIT cycles; the CPU is stalled for that cycle.
- Sits between the memory stage and the data memory instance. Drives the memory's WE/A/WD and observes its combinational RD.

---
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU memory
// stage and one external master. The CPU has priority. A saturating wait
// counter forces an EXT grant after MAX_WAIT refusals, and the CPU is
// stalled for that one cycle.
// Optional build macro DMEM_ARB_STATS_EN adds the stall_cnt and ext_cnt
// statistics counters.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   ext_cnt
`endif
);

  localparam int unsigned CW = 4;
  localparam int unsigned SW = 16;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  localparam logic [SW-1:0] STAT_MAX = {SW{1'b1}};

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic          ext_win;
  logic          cpu_win;

  // Grant decision, memory mux and combinational handshake outputs
  always_comb begin
    ext_win   = ext_req & (~cpu_req | (wait_cnt_q == WAIT_MAX));
    cpu_win   = cpu_req & ~ext_win;
    ext_gnt   = ext_win;
    cpu_stall = cpu_req & ext_win;
    cpu_rdata = mem_rdata;
    if (ext_win) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_we    = cpu_we & cpu_win;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Next-state for the wait counter and the registered EXT read response
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    ext_rvalid_d = 1'b0;
    ext_rdata_d  = ext_rdata_q;
    if (ext_win || !ext_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
    if (ext_win && !ext_we) begin
      ext_rvalid_d = 1'b1;
      ext_rdata_d  = mem_rdata;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [SW-1:0] ext_cnt_q, ext_cnt_d;

  // Saturating stall and EXT-grant counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    ext_cnt_d   = ext_cnt_q;
    if (cpu_stall && (stall_cnt_q != STAT_MAX)) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end
    if (ext_win && (ext_cnt_q != STAT_MAX)) begin
      ext_cnt_d = ext_cnt_q + SW'(1);
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      ext_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      ext_cnt_q   <= ext_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign ext_cnt   = ext_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a request-age based reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stall_cnt, ext_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Bench-owned data memory with combinational read
  logic [DW-1:0] tb_mem [0:63];
  logic          mem_clr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= '0;
    end else if (mem_we) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = tb_mem[mem_addr[7:2]];

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt), .ext_cnt(ext_cnt)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ext_req = 1'b0;
    ext_we  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_clr = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40; ext_wdata = '0;
    repeat (2) @(negedge clk);
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", ext_rvalid); end
    total++; if (ext_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", ext_rdata); end
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL reset_cpu_priority got=%0b exp=0", ext_gnt); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", cpu_stall); end
    next_cycle();
    rst = 1'b1; mem_clr = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    total++; if (ext_gnt !== 1'b1) begin bad++; $display("FAIL release_gnt got=%0b exp=1", ext_gnt); end
    total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL release_addr got=%h exp=40", mem_addr); end
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    total++; if (ext_rvalid !== 1'b1) begin bad++; $display("FAIL release_rvalid got=%0b exp=1", ext_rvalid); end
    next_cycle();
  endtask

  task automatic test_cpu_only();
    idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL cpu_store_we got=%0b exp=1", mem_we); end
    total++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_store_bus got=%h/%h exp=10/deadbeef", mem_addr, mem_wdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_store_stall got=%0b exp=0", cpu_stall); end
    next_cycle();
    cpu_we = 1'b0; cpu_wdata = '0;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL cpu_load_we got=%0b exp=0", mem_we); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_load_data got=%h exp=deadbeef", cpu_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_load_stall got=%0b exp=0", cpu_stall); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%0b exp=0", mem_we); end
    next_cycle();
  endtask

  task automatic test_ext_only();
    idle();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    @(negedge clk);
    total++; if (ext_gnt !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL ext_write gnt=%0b we=%0b exp=1/1", ext_gnt, mem_we); end
    next_cycle();
    ext_we = 1'b0; ext_wdata = '0;
    @(negedge clk);
    total++; if (ext_gnt !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL ext_read gnt=%0b we=%0b exp=1/0", ext_gnt, mem_we); end
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL ext_write_rvalid got=%0b exp=0", ext_rvalid); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin bad++; $display("FAIL ext_read_resp got=%0b/%h exp=1/12345678", ext_rvalid, ext_rdata); end
    next_cycle();
    @(negedge clk);
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h12345678) begin bad++; $display("FAIL ext_rvalid_pulse got=%0b/%h exp=0/12345678", ext_rvalid, ext_rdata); end
    next_cycle();
  endtask

  // CPU busy every cycle, EXT write raised at cycle 0: granted at cycle MAX_WAIT
  task automatic test_contention();
    logic exp_g;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80; ext_wdata = 32'hA5A50000 | 32'($urandom_range(0, 255));
    for (int c = 0; c <= int'(MAX_WAIT) + 1; c++) begin
      if (c == int'(MAX_WAIT) + 1) ext_req = 1'b0;
      @(negedge clk);
      exp_g = (c == int'(MAX_WAIT));
      total++; if (ext_gnt !== exp_g) begin bad++; $display("FAIL contention_gnt c=%0d got=%0b exp=%0b", c, ext_gnt, exp_g); end
      total++; if (cpu_stall !== exp_g) begin bad++; $display("FAIL contention_stall c=%0d got=%0b exp=%0b", c, cpu_stall, exp_g); end
      if (exp_g) begin
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== ext_wdata) begin bad++; $display("FAIL contention_bus got=%0b/%h/%h exp=1/80/%h", mem_we, mem_addr, mem_wdata, ext_wdata); end
      end else begin
        total++; if (mem_we !== 1'b0 || mem_addr !== 32'h10) begin bad++; $display("FAIL contention_cpu_bus c=%0d got=%0b/%h exp=0/10", c, mem_we, mem_addr); end
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL contention_rvalid got=%0b exp=0", ext_rvalid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic prev_stall = 1'b0;
    logic exp_g, exp_v;
    idle();
    for (int c = 0; c < 20; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0;
      if (!prev_stall) cpu_addr = 32'($urandom_range(0, 63) * 4);
      ext_req = 1'b1; ext_we = 1'b0;
      if (c % (int'(MAX_WAIT) + 1) == 0) ext_addr = 32'($urandom_range(0, 63) * 4);
      @(negedge clk);
      exp_g = (c % (int'(MAX_WAIT) + 1) == int'(MAX_WAIT));
      exp_v = (c > 0) && (c % (int'(MAX_WAIT) + 1) == 0);
      total++; if (ext_gnt !== exp_g) begin bad++; $display("FAIL b2b_gnt c=%0d got=%0b exp=%0b", c, ext_gnt, exp_g); end
      total++; if (ext_rvalid !== exp_v) begin bad++; $display("FAIL b2b_rvalid c=%0d got=%0b exp=%0b", c, ext_rvalid, exp_v); end
      total++; if (cpu_stall === 1'b1 && prev_stall) begin bad++; $display("FAIL b2b_double_stall c=%0d got=1 exp=0", c); end
      prev_stall = cpu_stall;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  // EXT drops its request before grant: age restarts on re-assertion
  task automatic test_drop();
    logic exp_g;
    idle();
    for (int c = 0; c < 9; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
      ext_req = (c != 2); ext_we = 1'b0; ext_addr = 32'h4;
      @(negedge clk);
      exp_g = (c == 3 + int'(MAX_WAIT));
      total++; if (ext_gnt !== exp_g) begin bad++; $display("FAIL drop_gnt c=%0d got=%0b exp=%0b", c, ext_gnt, exp_g); end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    idle();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
    @(negedge clk);
    total++; if (ext_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%0b exp=1", ext_gnt); end
    rst = 1'b0;
    ext_req = 1'b0;
    next_cycle();
    @(negedge clk);
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== '0) begin bad++; $display("FAIL rmid_rvalid got=%0b/%h exp=0/0", ext_rvalid, ext_rdata); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0b exp=0", ext_rvalid); end
    next_cycle();
  endtask

  // Randomized traffic against a request-age reference model
  task automatic test_random();
    logic [DW-1:0] ref_mem [0:63];
    int            age = 0;
    logic          e_g, e_s, e_we;
    logic          prev_s = 1'b0, prev_g = 1'b0;
    logic          e_v = 1'b0;
    logic [DW-1:0] e_rd = '0;
    logic [AW-1:0] e_addr;
    idle();
    mem_clr = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    next_cycle();
    mem_clr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!(cpu_req && prev_s)) begin
        cpu_req   = ($urandom_range(0, 9) < 7);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 32'($urandom_range(0, 63) * 4);
        cpu_wdata = $urandom;
      end
      if (!(ext_req && !prev_g)) begin
        ext_req   = ($urandom_range(0, 9) < 4);
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = 32'($urandom_range(0, 63) * 4);
        ext_wdata = $urandom;
      end
      @(negedge clk);
      e_g    = ext_req && (!cpu_req || age == int'(MAX_WAIT));
      e_s    = cpu_req && e_g;
      e_we   = e_g ? ext_we : (cpu_req && cpu_we);
      e_addr = e_g ? ext_addr : cpu_addr;
      total++; if (ext_gnt !== e_g) begin bad++; $display("FAIL rnd_gnt c=%0d got=%0b exp=%0b", c, ext_gnt, e_g); end
      total++; if (cpu_stall !== e_s) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, cpu_stall, e_s); end
      total++; if (mem_we !== e_we) begin bad++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, mem_we, e_we); end
      if (cpu_req || ext_req) begin
        total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, e_addr); end
      end
      if (cpu_req && !e_g && !cpu_we) begin
        total++; if (cpu_rdata !== ref_mem[cpu_addr[7:2]]) begin bad++; $display("FAIL rnd_cpu_rdata c=%0d got=%h exp=%h", c, cpu_rdata, ref_mem[cpu_addr[7:2]]); end
      end
      total++; if (ext_rvalid !== e_v || ext_rdata !== e_rd) begin bad++; $display("FAIL rnd_ext_resp c=%0d got=%0b/%h exp=%0b/%h", c, ext_rvalid, ext_rdata, e_v, e_rd); end
      e_v = e_g && !ext_we;
      if (e_v) e_rd = ref_mem[ext_addr[7:2]];
      if (e_g && ext_we) ref_mem[ext_addr[7:2]] = ext_wdata;
      else if (!e_g && cpu_req && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
      age    = e_g ? 0 : (ext_req ? age + 1 : 0);
      prev_s = e_s;
      prev_g = e_g;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    idle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (stall_cnt !== 16'd0 || ext_cnt !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", stall_cnt, ext_cnt); end
    next_cycle();
    for (int k = 0; k < 3; k++) test_contention();
    @(negedge clk);
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt); end
    total++; if (ext_cnt !== 16'd3) begin bad++; $display("FAIL stats_ext got=%0d exp=3", ext_cnt); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_only();
    test_ext_only();
    test_contention();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
